instruction_fetch_unit: RTL and testbench

Fetch stage directly downstream of the instruction address generator. It takes the current PC and issues a read to the instruction memory over a req/ack handshake. It latches the returned word into an instruction register for the decode stage over a valid/ready handshake, and pulses PC_enable back to the address generator so the PC advances exactly once per instruction. It also supports a flush for taken branches and jumps.

---
 rtl/instruction_fetch_unit_if.sv | 25 ++
 rtl/instruction_fetch_unit.sv | 156 +++++++++++++++
 tb/tb_instruction_fetch_unit.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instruction_fetch_unit_if.sv
// Fetch-unit bus bundle: instruction-memory read port plus the IR handoff to decode.
// master = fetch unit, slave = memory/decode side.
interface instruction_fetch_unit_if #(
    parameter int unsigned ADDR_W = 7,
    parameter int unsigned DATA_W = 32
);
    logic              Mem_req;
    logic [ADDR_W-1:0] Mem_addr;
    logic              Mem_ack;
    logic [DATA_W-1:0] Mem_rdata;
    logic [DATA_W-1:0] IR;
    logic [ADDR_W-1:0] IR_PC;
    logic              IR_valid;
    logic              IR_ready;

    modport master (
        output Mem_req, Mem_addr, IR, IR_PC, IR_valid,
        input  Mem_ack, Mem_rdata, IR_ready
    );

    modport slave (
        input  Mem_req, Mem_addr, IR, IR_PC, IR_valid,
        output Mem_ack, Mem_rdata, IR_ready
    );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch stage: reads the word at PC over a req/ack memory port, holds it in IR
// for decode (valid/ready), and pulses PC_enable once per delivered instruction.
module instruction_fetch_unit #(
    parameter int unsigned ADDR_W = 7,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 16
) (
    input  logic             Clock,
    input  logic             Reset_n,
    input  logic [31:0]      PC,
    output logic             PC_enable,
    input  logic             Flush,
    output logic [CNT_W-1:0] Fetch_count,
    instruction_fetch_unit_if.master bus
);

    typedef enum logic [2:0] {StStart, StReq, StSettle, StHold, StDrain} state_e;

    state_e state_q, state_d;

    logic              mem_req_q, mem_req_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] ir_q, ir_d;
    logic [ADDR_W-1:0] ir_pc_q, ir_pc_d;
    logic              ir_valid_q, ir_valid_d;
    logic              pc_enable_q, pc_enable_d;
    logic [CNT_W-1:0]  fetch_count_q, fetch_count_d;

    // Upper PC bits are deliberately ignored.
    logic unused_pc_hi;
    assign unused_pc_hi = ^PC[31:ADDR_W];

    // State register.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= StStart;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StStart:  state_d = Flush ? StStart : StReq;
            StReq: begin
                if (bus.Mem_ack && Flush) begin
                    state_d = StStart;
                end else if (Flush) begin
                    state_d = StDrain;
                end else if (bus.Mem_ack) begin
                    state_d = StSettle;
                end
            end
            StSettle: state_d = Flush ? StStart : StHold;
            StHold: begin
                // IR_valid already low means decode took it during SETTLE.
                if (Flush) begin
                    state_d = StStart;
                end else if (!ir_valid_q || bus.IR_ready) begin
                    state_d = StReq;
                end
            end
            StDrain:  state_d = bus.Mem_ack ? StStart : StDrain;
            default:  state_d = StStart;
        endcase
    end

    // Next values of the registered outputs.
    always_comb begin
        mem_req_d     = mem_req_q;
        mem_addr_d    = mem_addr_q;
        ir_d          = ir_q;
        ir_pc_d       = ir_pc_q;
        ir_valid_d    = ir_valid_q;
        pc_enable_d   = 1'b0;
        fetch_count_d = fetch_count_q;
        unique case (state_q)
            StStart: begin
                if (Flush) begin
                    ir_valid_d = 1'b0;
                end else begin
                    mem_addr_d = PC[ADDR_W-1:0];
                    mem_req_d  = 1'b1;
                end
            end
            StReq: begin
                if (bus.Mem_ack) begin
                    mem_req_d = 1'b0;
                    // A flush in the ack cycle discards the word.
                    if (!Flush) begin
                        ir_d          = bus.Mem_rdata;
                        ir_pc_d       = mem_addr_q;
                        ir_valid_d    = 1'b1;
                        pc_enable_d   = 1'b1;
                        fetch_count_d = fetch_count_q + CNT_W'(1);
                    end
                end
            end
            StSettle: begin
                if (Flush || (ir_valid_q && bus.IR_ready)) begin
                    ir_valid_d = 1'b0;
                end
            end
            StHold: begin
                if (Flush) begin
                    ir_valid_d = 1'b0;
                end else if (!ir_valid_q || bus.IR_ready) begin
                    ir_valid_d = 1'b0;
                    mem_addr_d = PC[ADDR_W-1:0];
                    mem_req_d  = 1'b1;
                end
            end
            StDrain: begin
                if (bus.Mem_ack) begin
                    mem_req_d = 1'b0;
                end
            end
            default: begin
                mem_req_d  = 1'b0;
                ir_valid_d = 1'b0;
            end
        endcase
    end

    // Output registers.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            mem_req_q     <= 1'b0;
            mem_addr_q    <= '0;
            ir_q          <= '0;
            ir_pc_q       <= '0;
            ir_valid_q    <= 1'b0;
            pc_enable_q   <= 1'b0;
            fetch_count_q <= '0;
        end else begin
            mem_req_q     <= mem_req_d;
            mem_addr_q    <= mem_addr_d;
            ir_q          <= ir_d;
            ir_pc_q       <= ir_pc_d;
            ir_valid_q    <= ir_valid_d;
            pc_enable_q   <= pc_enable_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    assign bus.Mem_req  = mem_req_q;
    assign bus.Mem_addr = mem_addr_q;
    assign bus.IR       = ir_q;
    assign bus.IR_PC    = ir_pc_q;
    assign bus.IR_valid = ir_valid_q;
    assign PC_enable    = pc_enable_q;
    assign Fetch_count  = fetch_count_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: vector table for straight-line fetching plus directed
// sequences for flush, async reset and counter wrap (the latter on a narrow-counter copy).
module tb_instruction_fetch_unit;

    localparam int unsigned ADDR_W = 7;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = 16;

    logic Clock = 1'b0;
    always #5 Clock = ~Clock;

    logic             Reset_n;
    logic [31:0]      PC;
    logic             PC_enable;
    logic             Flush;
    logic [CNT_W-1:0] Fetch_count;

    logic [31:0]      PC2;
    logic             PC_enable2;
    logic             Flush2;
    logic [3:0]       Fetch_count2;

    instruction_fetch_unit_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();
    instruction_fetch_unit_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus2 ();

    instruction_fetch_unit #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .Clock(Clock), .Reset_n(Reset_n), .PC(PC), .PC_enable(PC_enable), .Flush(Flush),
        .Fetch_count(Fetch_count), .bus(bus)
    );

    // Narrow counter copy so the wrap is reachable in a few dozen fetches.
    instruction_fetch_unit #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(4)) dut2 (
        .Clock(Clock), .Reset_n(Reset_n), .PC(PC2), .PC_enable(PC_enable2), .Flush(Flush2),
        .Fetch_count(Fetch_count2), .bus(bus2)
    );

    typedef struct {
        int          lat;
        int          stall;
        logic [6:0]  exp_pc;
        logic [31:0] exp_ir;
    } vec_t;

    vec_t vec [10];
    int   passed = 0;
    int   total  = 0;
    int   lat, cnt, pulses, pulses2;

    function automatic logic [31:0] mem_word(input logic [6:0] a);
        return 32'hC0DE_0000 | {25'h0, a};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // One clock: models run at the falling edge, then the caller samples/drives.
    task automatic cycle();
        @(negedge Clock);
        if (bus.Mem_ack) begin
            bus.Mem_ack = 1'b0;
            cnt = 0;
        end else if (bus.Mem_req) begin
            cnt++;
            if (cnt >= lat) begin
                bus.Mem_ack   = 1'b1;
                bus.Mem_rdata = mem_word(bus.Mem_addr);
            end
        end else begin
            cnt = 0;
        end
        if (PC_enable) begin
            PC = PC + 32'd1;
            pulses++;
        end
        if (bus2.Mem_ack) bus2.Mem_ack = 1'b0;
        else if (bus2.Mem_req) begin
            bus2.Mem_ack   = 1'b1;
            bus2.Mem_rdata = {25'h0, bus2.Mem_addr};
        end
        if (PC_enable2) begin
            PC2 = PC2 + 32'd1;
            pulses2++;
        end
    endtask

    task automatic rst(input logic [31:0] pc0, input int l);
        Reset_n = 1'b0;
        PC = pc0; lat = l; cnt = 0; Flush = 1'b0; bus.IR_ready = 1'b0;
        bus.Mem_ack = 1'b0; bus.Mem_rdata = '0;
        PC2 = 0; Flush2 = 1'b0; bus2.IR_ready = 1'b1; bus2.Mem_ack = 1'b0; bus2.Mem_rdata = '0;
        pulses = 0; pulses2 = 0;
        cycle();
        cycle();
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        while (!bus.IR_valid && n < 30) begin
            cycle();
            n++;
        end
        check(name, bus.IR_valid, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [6:0] nxt;
        vec[0] = '{3, 0, 7'd0, 32'hC0DE_0000};
        vec[1] = '{3, 0, 7'd1, 32'hC0DE_0001};
        vec[2] = '{3, 8, 7'd2, 32'hC0DE_0002};
        vec[3] = '{3, 0, 7'd3, 32'hC0DE_0003};
        vec[4] = '{1, 1, 7'd4, 32'hC0DE_0004};
        vec[5] = '{3, 0, 7'd5, 32'hC0DE_0005};
        vec[6] = '{5, 0, 7'd6, 32'hC0DE_0006};
        vec[7] = '{3, 2, 7'd7, 32'hC0DE_0007};
        vec[8] = '{2, 0, 7'd8, 32'hC0DE_0008};
        vec[9] = '{3, 0, 7'd9, 32'hC0DE_0009};

        // Reset state and first fetch from PC=5 with a 1-cycle memory.
        rst(32'h5, 1);
        bus.IR_ready = 1'b1;
        check("rst_req", bus.Mem_req, 0);
        check("rst_addr", bus.Mem_addr, 0);
        check("rst_ir", bus.IR, 0);
        check("rst_ir_pc", bus.IR_PC, 0);
        check("rst_valid", bus.IR_valid, 0);
        check("rst_pc_en", PC_enable, 0);
        check("rst_count", Fetch_count, 0);
        Reset_n = 1'b1;
        cycle();
        check("a_req", bus.Mem_req, 1);
        check("a_addr", bus.Mem_addr, 5);
        cycle();
        check("a_ir", bus.IR, 32'hC0DE_0005);
        check("a_ir_pc", bus.IR_PC, 5);
        check("a_valid", bus.IR_valid, 1);
        check("a_pc_en", PC_enable, 1);
        check("a_count", Fetch_count, 1);
        check("a_req_drop", bus.Mem_req, 0);
        cycle();
        check("a_pc_en_off", PC_enable, 0);
        check("a_consumed", bus.IR_valid, 0);
        cycle();
        check("a_next_addr", bus.Mem_addr, 6);
        check("a_next_req", bus.Mem_req, 1);
        check("a_pulses", pulses, 1);

        // Straight-line run PC=0..9 with varying latency and decode stalls.
        rst(32'h0, vec[0].lat);
        Reset_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            wait_valid($sformatf("v%0d_valid", i));
            check($sformatf("v%0d_ir_pc", i), bus.IR_PC, vec[i].exp_pc);
            check($sformatf("v%0d_ir", i), bus.IR, vec[i].exp_ir);
            check($sformatf("v%0d_pc_en", i), PC_enable, 1);
            check($sformatf("v%0d_count", i), Fetch_count, i + 1);
            lat = (i < 9) ? vec[i + 1].lat : 3;
            if (vec[i].stall == 0) begin
                bus.IR_ready = 1'b1;
                cycle();
                bus.IR_ready = 1'b0;
                check($sformatf("v%0d_taken", i), bus.IR_valid, 0);
            end else begin
                for (int s = 0; s < vec[i].stall; s++) cycle();
                check($sformatf("v%0d_stall_ir_pc", i), bus.IR_PC, vec[i].exp_pc);
                check($sformatf("v%0d_stall_ir", i), bus.IR, vec[i].exp_ir);
                check($sformatf("v%0d_stall_valid", i), bus.IR_valid, 1);
                check($sformatf("v%0d_stall_req", i), bus.Mem_req, 0);
                check($sformatf("v%0d_stall_pulses", i), pulses, i + 1);
                bus.IR_ready = 1'b1;
                cycle();
                bus.IR_ready = 1'b0;
                nxt = vec[i].exp_pc + 7'd1;
                check($sformatf("v%0d_resume_req", i), bus.Mem_req, 1);
                check($sformatf("v%0d_resume_addr", i), bus.Mem_addr, nxt);
            end
        end
        check("b_pulses", pulses, 10);
        check("b_count", Fetch_count, 10);

        // Flush during REQ (latency 4): in-flight word drained and dropped.
        rst(32'h20, 4);
        Reset_n = 1'b1;
        cycle();
        check("c_addr", bus.Mem_addr, 7'h20);
        cycle();
        Flush = 1'b1;
        PC = 32'h40;
        cycle();
        Flush = 1'b0;
        check("c_drain_req", bus.Mem_req, 1);
        cycle();
        cycle();
        check("c_valid", bus.IR_valid, 0);
        check("c_pulses", pulses, 0);
        check("c_count", Fetch_count, 0);
        check("c_req_off", bus.Mem_req, 0);
        cycle();
        check("c_redirect", bus.Mem_addr, 7'h40);
        wait_valid("c_valid40");
        check("c_ir_pc40", bus.IR_PC, 7'h40);
        check("c_ir40", bus.IR, 32'hC0DE_0040);
        check("c_count40", Fetch_count, 1);

        // Flush coincident with Mem_ack.
        lat = 2;
        bus.IR_ready = 1'b1;
        cycle();
        bus.IR_ready = 1'b0;
        cycle();
        check("f_addr41", bus.Mem_addr, 7'h41);
        cycle();
        Flush = 1'b1;
        PC = 32'h50;
        cycle();
        Flush = 1'b0;
        check("f_valid", bus.IR_valid, 0);
        check("f_pc_en", PC_enable, 0);
        check("f_count", Fetch_count, 1);
        check("f_ir_pc_hold", bus.IR_PC, 7'h40);
        check("f_req_off", bus.Mem_req, 0);
        cycle();
        check("f_redirect", bus.Mem_addr, 7'h50);
        wait_valid("f_valid50");
        check("f_ir_pc50", bus.IR_PC, 7'h50);
        check("f_count50", Fetch_count, 2);

        // Flush coincident with IR_ready in HOLD.
        cycle();
        bus.IR_ready = 1'b1;
        Flush = 1'b1;
        PC = 32'h60;
        cycle();
        Flush = 1'b0;
        bus.IR_ready = 1'b0;
        check("h_valid", bus.IR_valid, 0);
        check("h_req", bus.Mem_req, 0);
        check("h_count", Fetch_count, 2);
        check("h_pulses", pulses, 2);
        cycle();
        check("h_redirect", bus.Mem_addr, 7'h60);
        wait_valid("h_valid60");
        check("h_ir_pc60", bus.IR_PC, 7'h60);
        check("h_count60", Fetch_count, 3);

        // Asynchronous reset in the middle of a request.
        lat = 4;
        bus.IR_ready = 1'b1;
        cycle();
        bus.IR_ready = 1'b0;
        cycle();
        check("d_req_pre", bus.Mem_req, 1);
        check("d_addr_pre", bus.Mem_addr, 7'h61);
        #2;
        Reset_n = 1'b0;
        bus.Mem_ack = 1'b0;
        bus2.Mem_ack = 1'b0;
        pulses2 = 0;
        PC2 = 0;
        #1;
        check("d_req", bus.Mem_req, 0);
        check("d_addr", bus.Mem_addr, 0);
        check("d_ir", bus.IR, 0);
        check("d_ir_pc", bus.IR_PC, 0);
        check("d_valid", bus.IR_valid, 0);
        check("d_count", Fetch_count, 0);
        #4;
        Reset_n = 1'b1;
        cycle();
        check("d_start_req", bus.Mem_req, 0);
        cycle();
        check("d_restart_addr", bus.Mem_addr, 7'h61);
        wait_valid("d_valid61");
        check("d_ir_pc61", bus.IR_PC, 7'h61);
        check("d_count61", Fetch_count, 1);

        // Counter wrap on the 4-bit copy: 16 deliveries bring it back to 0.
        for (int n = 0; n < 300 && pulses2 < 16; n++) cycle();
        check("e_pulses16", pulses2, 16);
        check("e_wrap", Fetch_count2, 0);
        for (int n = 0; n < 30 && pulses2 < 17; n++) cycle();
        check("e_after_wrap", Fetch_count2, 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
